// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder: control/address in, registered one-hot and status out.
interface scan_decoder_if #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned NUM_OUT    = 4
);
    logic                  enable;
    logic                  mode;
    logic [ADDR_WIDTH-1:0] address;
    logic [NUM_OUT-1:0]    out;
    logic [ADDR_WIDTH-1:0] index;
    logic                  wrap;
    logic                  err;

    modport master (
        output enable, mode, address,
        input  out, index, wrap, err
    );

    modport slave (
        input  enable, mode, address,
        output out, index, wrap, err
    );
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-decode and prescaled auto-scan modes.
// Optional: define SCAN_DECODER_ACTIVE_LOW_EN for one-cold (active-low) out.
module scan_decoder #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned NUM_OUT    = 4,
    parameter int unsigned SCAN_DIV   = 1
) (
    input  logic           clk,
    input  logic           reset,
    scan_decoder_if.slave  bus
);

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_e;

    localparam int unsigned PW = 16;
    localparam logic [PW-1:0]         DIV_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_OUT - 1);
    localparam logic [ADDR_WIDTH:0]   NUM_OUT_X = (ADDR_WIDTH + 1)'(NUM_OUT);

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    localparam logic ACTIVE_LOW = 1'b1;
`else
    localparam logic ACTIVE_LOW = 1'b0;
`endif

    // Idle pattern doubles as the polarity mask applied to every decode.
    localparam logic [NUM_OUT-1:0] OUT_IDLE = {NUM_OUT{ACTIVE_LOW}};

    function automatic logic [NUM_OUT-1:0] decode(input logic [ADDR_WIDTH-1:0] idx);
        logic [NUM_OUT-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            v[k] = (idx == ADDR_WIDTH'(k));
        end
        return v ^ OUT_IDLE;
    endfunction

    state_e                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [NUM_OUT-1:0]    out_q,   out_d;
    logic                  wrap_q,  wrap_d;
    logic                  err_q,   err_d;

    // State register; state doubles as the registered previous mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_DIRECT;
            presc_q <= '0;
            index_q <= '0;
            out_q   <= OUT_IDLE;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            index_q <= index_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d = bus.mode ? ST_SCAN : ST_DIRECT;
        presc_d = presc_q;
        index_d = index_q;
        out_d   = OUT_IDLE;
        wrap_d  = 1'b0;
        err_d   = 1'b0;

        if (!bus.mode) begin
            presc_d = '0;
            if (bus.enable) begin
                if ({1'b0, bus.address} < NUM_OUT_X) begin
                    index_d = bus.address;
                    out_d   = decode(bus.address);
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (state_q == ST_DIRECT) begin
            // Entering scan: restart the prescaler, show the current index, never step.
            presc_d = '0;
            if (bus.enable) begin
                out_d = decode(index_q);
            end
        end else if (bus.enable) begin
            if (presc_q == DIV_LAST) begin
                presc_d = '0;
                if (index_q == LAST_IDX) begin
                    index_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    index_d = index_q + ADDR_WIDTH'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
            out_d = decode(index_d);
        end
    end

    assign bus.out   = out_q;
    assign bus.index = index_q;
    assign bus.wrap  = wrap_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: two instances (4 outputs / div 3, 5 outputs / div 1).
module tb_scan_decoder;

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    localparam logic ACT_LOW = 1'b1;
`else
    localparam logic ACT_LOW = 1'b0;
`endif

    typedef struct {
        bit         is_b;
        logic [4:0] out;
        logic [2:0] idx;
        logic       wrap;
        logic       err;
        string      nm;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_chk;
    int   n_pass;
    exp_t sb_q[$];

    scan_decoder_if #(.ADDR_WIDTH(2), .NUM_OUT(4)) if_a ();
    scan_decoder_if #(.ADDR_WIDTH(3), .NUM_OUT(5)) if_b ();

    scan_decoder #(.ADDR_WIDTH(2), .NUM_OUT(4), .SCAN_DIV(3)) u_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (if_a)
    );

    scan_decoder #(.ADDR_WIDTH(3), .NUM_OUT(5), .SCAN_DIV(1)) u_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (if_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Drive one cycle of stimulus at a negedge and queue the expected registered result.
    task automatic cyc(input bit b, input logic en, input logic md, input logic [2:0] addr,
                       input logic [4:0] eo, input logic [2:0] ei, input logic ew,
                       input logic ee, input string nm);
        exp_t e;
        if (b) begin
            if_b.enable  = en;
            if_b.mode    = md;
            if_b.address = addr;
        end else begin
            if_a.enable  = en;
            if_a.mode    = md;
            if_a.address = addr[1:0];
        end
        e.is_b = b;
        e.out  = eo;
        e.idx  = ei;
        e.wrap = ew;
        e.err  = ee;
        e.nm   = nm;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every edge with a pending expectation is checked 2 time units later.
    initial begin
        exp_t       e;
        logic [4:0] ao;
        logic [4:0] mask;
        logic [4:0] pol;
        logic [2:0] ai;
        logic       aw;
        logic       ae;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.is_b) begin
                    ao = if_b.out;  ai = if_b.index;    aw = if_b.wrap; ae = if_b.err;
                    mask = 5'h1f;
                end else begin
                    ao = 5'(if_a.out); ai = 3'(if_a.index); aw = if_a.wrap; ae = if_a.err;
                    mask = 5'h0f;
                end
                pol = ACT_LOW ? mask : 5'h00;
                chk({e.nm, ".out"},   8'(ao),   8'(e.out ^ pol));
                chk({e.nm, ".index"}, 8'(ai),   8'(e.idx));
                chk({e.nm, ".wrap"},  8'(aw),   8'(e.wrap));
                chk({e.nm, ".err"},   8'(ae),   8'(e.err));
                chk({e.nm, ".onehot"}, 8'($countones(ao ^ pol) <= 1), 8'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int i;
        n_chk  = 0;
        n_pass = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.enable = 1'b0; if_a.mode = 1'b0; if_a.address = '0;
        if_b.enable = 1'b0; if_b.mode = 1'b0; if_b.address = '0;

        #3;
        chk("reset_a.out",   8'(if_a.out),   ACT_LOW ? 8'h0f : 8'h00);
        chk("reset_a.index", 8'(if_a.index), 8'h00);
        chk("reset_a.wrap",  8'(if_a.wrap),  8'h00);
        chk("reset_a.err",   8'(if_a.err),   8'h00);
        chk("reset_b.out",   8'(if_b.out),   ACT_LOW ? 8'h1f : 8'h00);

        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Direct decode, 4 outputs
        cyc(0, 1, 0, 3'd0, 5'b00001, 3'd0, 0, 0, "a_dir0");
        cyc(0, 1, 0, 3'd1, 5'b00010, 3'd1, 0, 0, "a_dir1");
        cyc(0, 1, 0, 3'd2, 5'b00100, 3'd2, 0, 0, "a_dir2");
        cyc(0, 1, 0, 3'd3, 5'b01000, 3'd3, 0, 0, "a_dir3");
        cyc(0, 0, 0, 3'd1, 5'b00000, 3'd3, 0, 0, "a_dis");
        cyc(0, 1, 0, 3'd0, 5'b00001, 3'd0, 0, 0, "a_dir0b");

        // Scan, SCAN_DIV=3: index steps every 3 edges, wrap on the 3->0 step (edge 12)
        for (int e = 0; e < 20; e++) begin
            i = (e / 3) % 4;
            cyc(0, 1, 1, 3'd0, 5'(1 << i), 3'(i), logic'(e == 12), 0, "a_scan");
        end

        // Now at index 2, prescaler 1: freeze for 5 cycles, then resume
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 3'd0, 5'b00000, 3'd2, 0, 0, "a_frz");
        cyc(0, 1, 1, 3'd0, 5'b00100, 3'd2, 0, 0, "a_res1");
        cyc(0, 1, 1, 3'd0, 5'b01000, 3'd3, 0, 0, "a_res2");
        cyc(0, 1, 1, 3'd0, 5'b01000, 3'd3, 0, 0, "a_res3");

        // Leaving scan: next edge is a plain direct decode
        cyc(0, 1, 0, 3'd1, 5'b00010, 3'd1, 0, 0, "a_back");
        cyc(0, 0, 0, 3'd0, 5'b00000, 3'd1, 0, 0, "a_idle");

        // Out-of-range, 5 outputs on 3 address bits
        cyc(1, 1, 0, 3'd2, 5'b00100, 3'd2, 0, 0, "b_dir2");
        cyc(1, 1, 0, 3'd6, 5'b00000, 3'd2, 0, 1, "b_oor6");
        cyc(1, 1, 0, 3'd4, 5'b10000, 3'd4, 0, 0, "b_dir4");
        cyc(1, 1, 0, 3'd5, 5'b00000, 3'd4, 0, 1, "b_oor5");
        cyc(1, 0, 0, 3'd7, 5'b00000, 3'd4, 0, 0, "b_dis");
        cyc(1, 1, 0, 3'd0, 5'b00001, 3'd0, 0, 0, "b_dir0");

        // Scan, SCAN_DIV=1: entry edge shows index 0, then one step per edge
        for (int e = 0; e < 4; e++) begin
            cyc(1, 1, 1, 3'd0, 5'(1 << e), 3'(e), 0, 0, "b_scan");
        end

        // Async reset between edges at index 3
        #2;
        rst_b = 1'b1;
        #1;
        chk("b_rst.out",   8'(if_b.out),   ACT_LOW ? 8'h1f : 8'h00);
        chk("b_rst.index", 8'(if_b.index), 8'h00);
        chk("b_rst.wrap",  8'(if_b.wrap),  8'h00);
        @(negedge clk);
        rst_b = 1'b0;

        // Scan restarts from 0 and wraps after index 4
        for (int e = 0; e < 7; e++) begin
            i = e % 5;
            cyc(1, 1, 1, 3'd0, 5'(1 << i), 3'(i), logic'(e == 5), 0, "b_rescan");
        end
        cyc(1, 0, 0, 3'd0, 5'b00000, 3'd1, 0, 0, "b_end");

        repeat (3) @(posedge clk);
        #3;
        chk("sb_drain", 8'(sb_q.size()), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
Parametrised registered one-hot decoder. Generalises the 2-to-4 enable decoder to ADDR_WIDTH address bits and NUM_OUT outputs. Adds an auto-scan mode in which an internal counter walks the outputs in turn, for multiplexed displays, bank strobes and register-file write-enable sequencing. Sits between control logic and per-channel enables; all outputs are registered.

Parameters:
ADDR_WIDTH, 2, address/index width in bits.
NUM_OUT, 4, number of one-hot outputs; legal range 2 to 2**ADDR_WIDTH.
SCAN_DIV, 1, clock cycles per scan step; legal range 1 to 65535; prescaler width is 16 bits.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  global enable; low forces out to zero and freezes the scan.
mode  input  1  0 = direct decode, 1 = auto-scan.
address  input  ADDR_WIDTH  decode address; used in direct mode only.
out  output  NUM_OUT  registered one-hot outputs; bit k is high when the selected index is k.
index  output  ADDR_WIDTH  currently selected index, registered.
wrap  output  1  one-cycle pulse when a scan step goes from NUM_OUT-1 to 0.
err  output  1  registered flag: direct-mode address is at or above NUM_OUT while enable is high.

Behaviour:
- Reset (asynchronous, active-high): takes effect immediately, independent of clk.
  - out=0, index=0, wrap=0, err=0.
  - Prescaler=0; mode-history register=0.
  - Reset mid-scan abandons the scan position; after release the scan restarts from index 0.
- Invariant: out has at most one bit set, on every cycle.
- Direct mode (mode=0), evaluated at each rising clk edge, latency 1 cycle:
  - enable=1, address<NUM_OUT: out<=one-hot(address), index<=address, err<=0.
  - enable=1, address>=NUM_OUT: out<=0, index holds, err<=1.
  - enable=0: out<=0, index holds, err<=0.
  - wrap<=0 and prescaler<=0 in direct mode.
- Scan mode (mode=1):
  - err<=0 in scan mode.
  - enable=1: prescaler increments each cycle.
  - When prescaler==SCAN_DIV-1: prescaler<=0, index<=index+1. If index==NUM_OUT-1, index<=0 and wrap<=1 for that cycle only.
  - Otherwise wrap<=0 and index holds.
  - out<=one-hot(next index) on the same edge as index, so out and index are always consistent.
  - enable=0: prescaler and index hold, out<=0, wrap<=0. Re-asserting enable resumes from the held prescaler and index values.
  - SCAN_DIV=1: index advances every enabled cycle; wrap fires every NUM_OUT cycles.
- Mode transitions (detected against the registered previous mode):
  - 0->1: prescaler cleared; the scan starts from the current index. The first step occurs SCAN_DIV enabled cycles after mode first samples 1. out shows one-hot(index) on the first scan-mode edge.
  - 1->0: the next edge performs a direct decode; the scan position is discarded.
- Simultaneous events:
  - mode change and step on the same edge: the mode change wins, so no step and no wrap.
  - enable falling on a step edge: no step.
- Arithmetic: index increment is ADDR_WIDTH bits with explicit compare against NUM_OUT-1. No reliance on natural wrap, because NUM_OUT may be less than 2**ADDR_WIDTH.

Optional Feature:
Macro SCAN_DECODER_ACTIVE_LOW_EN.
- Defined: the out port is the bitwise inverse of the one-hot value (one-cold).
  - Reset value and disabled value are all ones.
  - index, wrap and err are unchanged.
- Undefined: out is active-high as described above; reset value is all zeros.

Test Plan:
- Direct decode (ADDR_WIDTH=2, NUM_OUT=4): enable=1, mode=0, address 0,1,2,3 on successive cycles -> out 0001,0010,0100,1000, each one cycle after the address; enable=0 -> out=0000 next cycle.
- Out-of-range (ADDR_WIDTH=3, NUM_OUT=5): address=6 -> out=00000, err=1, index holds previous value; then address=4 -> out=10000, err=0.
- Scan wrap (NUM_OUT=4, SCAN_DIV=3): mode=1, enable=1 from index 0 -> index steps every 3 cycles 0,1,2,3,0; wrap high for exactly one cycle at the 3->0 step; out stays one-hot throughout.
- Freeze and resume (SCAN_DIV=3): drop enable for 5 cycles mid-scan at index 2 with prescaler 1 -> out=0, index=2 held; re-enable -> step to 3 after 2 more cycles.
- Async reset mid-scan (SCAN_DIV=1): assert reset between clock edges at index 3 -> out, index and wrap are 0 immediately; after release -> scan resumes 0,1,2,...
- With SCAN_DECODER_ACTIVE_LOW_EN defined: repeat the direct-decode test -> out 1110,1101,1011,0111; reset value 1111.
